// File: rtl/sysarr_pkg.sv
// Shared types for the systolic-array memory sequencer: FSM state encoding
// (also the state_o encoding) and dataflow mode codes.
package sysarr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_AS_CALC  = 3'd1,
        ST_AS_DRAIN = 3'd2,
        ST_SA_LOAD  = 3'd3,
        ST_SA_CALC  = 3'd4,
        ST_FLUSH    = 3'd5
    } state_t;

    localparam logic [1:0] MODE_AS = 2'b01;
    localparam logic [1:0] MODE_SA = 2'b10;

    function automatic logic mode_legal(input logic [1:0] m);
        return (m == MODE_AS) || (m == MODE_SA);
    endfunction

endpackage

// File: rtl/sysarr_wr_delay.sv
// Write-issue delay line: carries {valid, addr} through WR_LAT register stages
// so the write strobe lines up with BRAM read latency plus the adder stage.
module sysarr_wr_delay
    import sysarr_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WR_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              issue_vld,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    logic              vld_p  [WR_LAT];
    logic [ADDR_W-1:0] addr_p [WR_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WR_LAT; i++) begin
                vld_p[i]  <= 1'b0;
                addr_p[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < WR_LAT; i++) begin
                vld_p[i]  <= 1'b0;
                addr_p[i] <= '0;
            end
        end else begin
            vld_p[0]  <= issue_vld;
            addr_p[0] <= issue_addr;
            for (int i = 1; i < WR_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                addr_p[i] <= addr_p[i-1];
            end
        end
    end

    assign wr_en   = vld_p[WR_LAT-1];
    assign wr_addr = addr_p[WR_LAT-1];

endmodule

// File: rtl/sysarr_mem_seq.sv
// Memory sequencer for the systolic-array multiplier: generates BRAM read/write
// addresses for the AS and SA dataflows and steers operand data into the array.
module sysarr_mem_seq
    import sysarr_pkg::*;
#(
    parameter int ARRAY_DIM = 4,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32,
    parameter int ROWS_W    = 11,
    parameter int WR_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              abort,
    input  logic [ROWS_W-1:0] matrix_rows,
    input  logic [ADDR_W-1:0] base_left,
    input  logic [ADDR_W-1:0] base_right,
    input  logic [ADDR_W-1:0] base_add,
    input  logic [ADDR_W-1:0] base_save,
    input  logic [ADDR_W-1:0] line_stride,
    input  logic [ADDR_W-1:0] plane_left,
    input  logic [ADDR_W-1:0] plane_right,
    input  logic [DATA_W-1:0] rd_data_0,
    input  logic [DATA_W-1:0] rd_data_1,
    input  logic [DATA_W-1:0] rd_data_2,
    output logic [ADDR_W-1:0] rd_addr_0,
    output logic [ADDR_W-1:0] rd_addr_1,
    output logic [ADDR_W-1:0] rd_addr_2,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] data_left,
    output logic [DATA_W-1:0] data_right,
    output logic [DATA_W-1:0] data_adder,
    output logic              sa_compute,
    output logic              sa_mode,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_o,
    output logic              tp_select,
    output logic              tp_rst
);

    localparam int PW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
    localparam int LW = ROWS_W + 1;
    localparam int FW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
    localparam logic [LW-1:0] DIM_L   = LW'(ARRAY_DIM);
    localparam logic [LW-1:0] ONE_L   = LW'(1);
    localparam logic [FW-1:0] FL_LAST = FW'(WR_LAT - 1);

    state_t            state, state_d;
    logic [PW-1:0]     ph;
    logic [LW-1:0]     line;
    logic [FW-1:0]     fcnt;
    logic              err_r, done_r, tp_rst_r, tp_sel_r, sa_mode_r;

    logic [ROWS_W-1:0] n_cfg;
    logic [ADDR_W-1:0] base_add_r, base_save_r, stride_r, plane_l_r, plane_r_r;
    logic [ADDR_W-1:0] lb_l, lb_r, ob, off_l, off_r, off_s, rev_off;

    logic              ph_last, busy_w, cfg_ok, start_ok, start_bad, flush_end;
    logic [LW-1:0]     n_l;
    logic              iss_vld;
    logic [ADDR_W-1:0] iss_addr;

    assign ph_last   = &ph;
    assign busy_w    = (state != ST_IDLE);
    assign n_l       = {1'b0, n_cfg};
    assign cfg_ok    = (matrix_rows != '0) && mode_legal(mode);
    assign start_ok  = start && !abort && (state == ST_IDLE) && cfg_ok;
    assign start_bad = start && !abort && (state == ST_IDLE) && !cfg_ok;
    assign flush_end = (state == ST_FLUSH) && (fcnt == FL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d    = state;
        rd_addr_0  = '0;
        rd_addr_1  = '0;
        rd_addr_2  = '0;
        data_left  = '0;
        data_right = '0;
        sa_compute = 1'b0;
        iss_vld    = 1'b0;
        iss_addr   = '0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_d = (mode == MODE_AS) ? ST_AS_CALC : ST_SA_LOAD;
            end
            ST_AS_CALC: begin
                sa_compute = 1'b1;
                rd_addr_0  = lb_l + off_l;
                rd_addr_1  = lb_r + off_r;
                data_left  = rd_data_0;
                data_right = rd_data_1;
                if (ph_last && (line == n_l - ONE_L)) state_d = ST_AS_DRAIN;
            end
            ST_AS_DRAIN: begin
                // Only the final line period reads the accumulator and writes results.
                if (line == DIM_L - ONE_L) begin
                    rd_addr_0 = base_add_r + off_s;
                    iss_vld   = 1'b1;
                    iss_addr  = base_save_r + off_s;
                    if (ph_last) state_d = ST_FLUSH;
                end else begin
                    sa_compute = 1'b1;
                end
            end
            ST_SA_LOAD: begin
                rd_addr_0  = lb_r + rev_off;
                data_right = rd_data_0;
                if (ph_last) state_d = ST_SA_CALC;
            end
            ST_SA_CALC: begin
                sa_compute = 1'b1;
                if (line < n_l) begin
                    rd_addr_2 = lb_l + off_l;
                    data_left = rd_data_2;
                end
                if (line >= DIM_L) begin
                    rd_addr_0 = base_add_r + ob + off_l;
                    iss_vld   = 1'b1;
                    iss_addr  = base_save_r + ob + off_l;
                end
                if (ph_last && (line == n_l + DIM_L - ONE_L)) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (fcnt == FL_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph        <= '0;
            line      <= '0;
            fcnt      <= '0;
            err_r     <= 1'b0;
            done_r    <= 1'b0;
            tp_rst_r  <= 1'b0;
            tp_sel_r  <= 1'b1;
            sa_mode_r <= 1'b0;
        end else begin
            err_r    <= start_bad;
            tp_rst_r <= start_ok;
            done_r   <= flush_end && !abort;
            if (start_ok) begin
                ph        <= '0;
                line      <= '0;
                fcnt      <= '0;
                tp_sel_r  <= 1'b1;
                sa_mode_r <= (mode == MODE_AS);
            end else if (busy_w) begin
                ph <= ph + PW'(1);
                if (ph == '0) tp_sel_r <= !tp_sel_r;
                // Every state transition restarts the line count for the new phase.
                if (state_d != state) line <= '0;
                else if (ph_last)     line <= line + ONE_L;
                fcnt <= (state == ST_FLUSH) ? fcnt + FW'(1) : '0;
            end
        end
    end

    // Address accumulators replace line*stride and ph*plane products.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            n_cfg       <= matrix_rows;
            base_add_r  <= base_add;
            base_save_r <= base_save;
            stride_r    <= line_stride;
            plane_l_r   <= plane_left;
            plane_r_r   <= plane_right;
            lb_l        <= base_left;
            lb_r        <= base_right;
            ob          <= '0;
            off_l       <= '0;
            off_r       <= '0;
            off_s       <= '0;
            rev_off     <= (plane_right << PW) - plane_right;
        end else if (busy_w) begin
            off_l   <= ph_last ? '0 : off_l + plane_l_r;
            off_r   <= ph_last ? '0 : off_r + plane_r_r;
            off_s   <= ph_last ? '0 : off_s + stride_r;
            rev_off <= rev_off - plane_r_r;
            if (ph_last && ((state == ST_AS_CALC) || (state == ST_SA_CALC))) lb_l <= lb_l + stride_r;
            if (ph_last && (state == ST_AS_CALC)) lb_r <= lb_r + stride_r;
            if (ph_last && (state == ST_SA_CALC) && (line >= DIM_L)) ob <= ob + stride_r;
        end
    end

    sysarr_wr_delay #(
        .ADDR_W (ADDR_W),
        .WR_LAT (WR_LAT)
    ) u_wr_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (abort),
        .issue_vld  (iss_vld),
        .issue_addr (iss_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr)
    );

    assign data_adder = rd_data_0;
    assign sa_mode    = sa_mode_r;
    assign busy       = busy_w;
    assign done       = done_r;
    assign err        = err_r;
    assign state_o    = state;
    assign tp_select  = tp_sel_r;
    assign tp_rst     = tp_rst_r;

endmodule

// File: tb/tb_sysarr_mem_seq.sv
// Self-checking bench for sysarr_mem_seq: per-cycle address/control model plus
// a write scoreboard of {addr, arrival cycle} entries.
`timescale 1ns/1ps
module tb_sysarr_mem_seq;
    import sysarr_pkg::*;

    localparam int DIM = 4;
    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int RW  = 11;
    localparam int WL  = 3;
    localparam logic [DW-1:0] D0 = 64'hA0A0_1111_2222_00A0;
    localparam logic [DW-1:0] D1 = 64'hB1B1_3333_4444_00B1;
    localparam logic [DW-1:0] D2 = 64'hC2C2_5555_6666_00C2;

    logic          clk, rst_n, start, abort;
    logic [1:0]    mode;
    logic [RW-1:0] matrix_rows;
    logic [AW-1:0] base_left, base_right, base_add, base_save, line_stride, plane_left, plane_right;
    logic [DW-1:0] rd_data_0, rd_data_1, rd_data_2;
    logic [AW-1:0] rd_addr_0, rd_addr_1, rd_addr_2, wr_addr;
    logic [DW-1:0] data_left, data_right, data_adder;
    logic          wr_en, sa_compute, sa_mode, busy, done, err, tp_select, tp_rst;
    logic [2:0]    state_o;

    sysarr_mem_seq #(
        .ARRAY_DIM (DIM), .DATA_W (DW), .ADDR_W (AW), .ROWS_W (RW), .WR_LAT (WL)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .mode (mode), .abort (abort),
        .matrix_rows (matrix_rows), .base_left (base_left), .base_right (base_right),
        .base_add (base_add), .base_save (base_save), .line_stride (line_stride),
        .plane_left (plane_left), .plane_right (plane_right),
        .rd_data_0 (rd_data_0), .rd_data_1 (rd_data_1), .rd_data_2 (rd_data_2),
        .rd_addr_0 (rd_addr_0), .rd_addr_1 (rd_addr_1), .rd_addr_2 (rd_addr_2),
        .wr_en (wr_en), .wr_addr (wr_addr), .data_left (data_left), .data_right (data_right),
        .data_adder (data_adder), .sa_compute (sa_compute), .sa_mode (sa_mode), .busy (busy),
        .done (done), .err (err), .state_o (state_o), .tp_select (tp_select), .tp_rst (tp_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    logic [1:0]    cfg_mode;
    int            cfg_n;
    logic [AW-1:0] cfg_bl, cfg_br, cfg_ba, cfg_st, cfg_pl, cfg_pr;

    typedef struct {
        logic [AW-1:0] addr;
        int            when;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    // Write scoreboard: every wr_en must match the oldest expected write, at its cycle.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL wr_unexpected: got wr_en=1 addr=%h at cycle %0d, required no write", wr_addr, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (wr_addr !== mon_e.addr)
                    $display("FAIL wr_addr: got %h required %h", wr_addr, mon_e.addr);
                else n_pass++;
                n_total++;
                if (cyc !== mon_e.when)
                    $display("FAIL wr_time: got cycle %0d required %0d (addr %h)", cyc, mon_e.when, mon_e.addr);
                else n_pass++;
            end
        end
    end

    function automatic void model(input int b, output logic [AW-1:0] r0, r1, r2,
                                  output logic sc, output logic [DW-1:0] dl, dr);
        int line, ph, ll;
        r0 = '0; r1 = '0; r2 = '0; sc = 1'b0; dl = '0; dr = '0;
        ph = b % DIM;
        if (cfg_mode == MODE_AS) begin
            if (b < DIM * cfg_n) begin
                line = b / DIM;
                sc = 1'b1;
                r0 = cfg_bl + 32'(line) * cfg_st + 32'(ph) * cfg_pl;
                r1 = cfg_br + 32'(line) * cfg_st + 32'(ph) * cfg_pr;
                dl = D0;
                dr = D1;
            end else if (b < DIM * cfg_n + DIM * (DIM - 1)) begin
                sc = 1'b1;
            end else if (b < DIM * cfg_n + DIM * DIM) begin
                r0 = cfg_ba + 32'(ph) * cfg_st;
            end
        end else begin
            if (b < DIM) begin
                r0 = cfg_br + 32'(DIM - 1 - b) * cfg_pr;
                dr = D0;
            end else if (b < DIM + DIM * (cfg_n + DIM)) begin
                ll = (b - DIM) / DIM;
                sc = 1'b1;
                if (ll < cfg_n) begin
                    r2 = cfg_bl + 32'(ll) * cfg_st + 32'(ph) * cfg_pl;
                    dl = D2;
                end
                if (ll >= DIM) r0 = cfg_ba + 32'(ll - DIM) * cfg_st + 32'(ph) * cfg_pl;
            end
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00; matrix_rows = '0;
        base_left = '0; base_right = '0; base_add = '0; base_save = '0;
        line_stride = '0; plane_left = '0; plane_right = '0;
        rd_data_0 = '0; rd_data_1 = '0; rd_data_2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({busy, done, err, wr_en, tp_rst, sa_compute, sa_mode} !== 7'b0)
            $display("FAIL reset_ctrl: got %b required 0000000", {busy, done, err, wr_en, tp_rst, sa_compute, sa_mode});
        else n_pass++;
        n_total++;
        if (tp_select !== 1'b1) $display("FAIL reset_tp_select: got %b required 1", tp_select);
        else n_pass++;
        n_total++;
        if ({rd_addr_0, rd_addr_1, rd_addr_2, wr_addr} !== 128'h0)
            $display("FAIL reset_addr: got %h/%h/%h/%h required 0", rd_addr_0, rd_addr_1, rd_addr_2, wr_addr);
        else n_pass++;
        n_total++;
        if (state_o !== 3'd0) $display("FAIL reset_state: got %0d required 0", state_o);
        else n_pass++;
        rst_n = 1'b1;
        rd_data_0 = D0; rd_data_1 = D1; rd_data_2 = D2;
        @(negedge clk);
        n_total++;
        if ({busy, state_o} !== 4'b0) $display("FAIL post_reset_idle: got busy=%b state=%0d required 0/0", busy, state_o);
        else n_pass++;
    endtask

    task automatic test_full_run(input string nm, input logic [1:0] md, input int n,
                                 input logic [AW-1:0] bl, br, ba, bs, st, pl, pr);
        int s, total;
        logic [AW-1:0] r0, r1, r2;
        logic sc, tps;
        logic [DW-1:0] dl, dr;
        wr_t w;
        cfg_mode = md; cfg_n = n; cfg_bl = bl; cfg_br = br; cfg_ba = ba; cfg_st = st; cfg_pl = pl; cfg_pr = pr;
        @(posedge clk); #1;
        mode = md; matrix_rows = RW'(n); base_left = bl; base_right = br; base_add = ba;
        base_save = bs; line_stride = st; plane_left = pl; plane_right = pr; start = 1'b1;
        s = cyc + 1;
        if (md == MODE_AS) begin
            total = DIM * n + DIM * DIM + WL;
            for (int k = 0; k < DIM; k++) begin
                w.addr = bs + 32'(k) * st;
                w.when = s + DIM * n + DIM * (DIM - 1) + k + WL;
                exp_q.push_back(w);
            end
        end else begin
            total = DIM + DIM * (n + DIM) + WL;
            for (int l = DIM; l < n + DIM; l++)
                for (int p = 0; p < DIM; p++) begin
                    w.addr = bs + 32'(l - DIM) * st + 32'(p) * pl;
                    w.when = s + DIM + DIM * l + p + WL;
                    exp_q.push_back(w);
                end
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < total; b++) begin
            @(negedge clk);
            model(b, r0, r1, r2, sc, dl, dr);
            tps = ((((b + DIM - 1) / DIM) % 2) == 0);
            n_total++;
            if ({rd_addr_0, rd_addr_1, rd_addr_2} !== {r0, r1, r2})
                $display("FAIL %s rd_addr b=%0d: got %h/%h/%h required %h/%h/%h", nm, b,
                         rd_addr_0, rd_addr_1, rd_addr_2, r0, r1, r2);
            else n_pass++;
            n_total++;
            if ({busy, done, err, sa_compute, tp_select, tp_rst} !== {1'b1, 1'b0, 1'b0, sc, tps, (b == 0)})
                $display("FAIL %s ctrl b=%0d: got busy/done/err/sc/tps/tpr=%b required %b", nm, b,
                         {busy, done, err, sa_compute, tp_select, tp_rst},
                         {1'b1, 1'b0, 1'b0, sc, tps, (b == 0)});
            else n_pass++;
            n_total++;
            if ({data_left, data_right, data_adder} !== {dl, dr, D0})
                $display("FAIL %s data b=%0d: got %h/%h/%h required %h/%h/%h", nm, b,
                         data_left, data_right, data_adder, dl, dr, D0);
            else n_pass++;
            if (b == 0) begin
                n_total++;
                if (sa_mode !== (md == MODE_AS)) $display("FAIL %s sa_mode: got %b required %b", nm, sa_mode, md == MODE_AS);
                else n_pass++;
            end
        end
        @(negedge clk);
        n_total++;
        if ({done, busy, state_o} !== 5'b10000)
            $display("FAIL %s done: got done=%b busy=%b state=%0d required 1/0/0", nm, done, busy, state_o);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL %s writes_missing: got %0d outstanding required 0", nm, exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_as_basic();
        test_full_run("as_basic", MODE_AS, 3, 32'h0, 32'h1000, 32'h2000, 32'h3000, 32'h40, 32'h100, 32'h100);
    endtask

    task automatic test_sa_basic();
        test_full_run("sa_basic", MODE_SA, 2, 32'h0, 32'h1000, 32'h2000, 32'h3000, 32'h40, 32'h100, 32'h100);
    endtask

    task automatic test_wrap();
        test_full_run("as_wrap", MODE_AS, 2, 32'hFFFF_FFC0, 32'h1000, 32'h2000, 32'h3000, 32'h40, 32'h10, 32'h200);
    endtask

    task automatic test_reject();
        logic [1:0] bad_mode [2];
        int         bad_n    [2];
        bad_mode[0] = 2'b11; bad_n[0] = 3;
        bad_mode[1] = MODE_SA; bad_n[1] = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            mode = bad_mode[i]; matrix_rows = RW'(bad_n[i]); base_left = 32'h5550; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            n_total++;
            if ({err, busy, state_o} !== 5'b10000)
                $display("FAIL reject%0d err: got err=%b busy=%b state=%0d required 1/0/0", i, err, busy, state_o);
            else n_pass++;
            n_total++;
            if ({rd_addr_0, rd_addr_2, sa_mode, tp_rst} !== {64'h0, 1'b1, 1'b0})
                $display("FAIL reject%0d regs: got rd0=%h rd2=%h sa_mode=%b tp_rst=%b required 0/0/1/0", i,
                         rd_addr_0, rd_addr_2, sa_mode, tp_rst);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if ({err, busy} !== 2'b00) $display("FAIL reject%0d pulse: got err=%b busy=%b required 0/0", i, err, busy);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        @(posedge clk); #1;
        mode = MODE_SA; matrix_rows = RW'(2); base_left = 32'h0; base_right = 32'h1000;
        base_add = 32'h2000; base_save = 32'h3000; line_stride = 32'h40;
        plane_left = 32'h100; plane_right = 32'h100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (DIM + 5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b1;
        @(negedge clk);
        n_total++;
        if ({busy, done, wr_en, state_o} !== 6'b0)
            $display("FAIL abort1_idle: got busy=%b done=%b wr_en=%b state=%0d required 0/0/0/0", busy, done, wr_en, state_o);
        else n_pass++;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < WL + 2; i++) begin
            @(negedge clk);
            n_total++;
            if ({busy, done, wr_en} !== 3'b100)
                $display("FAIL abort_restart c=%0d: got busy=%b done=%b wr_en=%b required 1/0/0", i, busy, done, wr_en);
            else n_pass++;
        end
        // Restarted run is at busy cycle WL+1; abort it while writes are in flight.
        repeat (DIM + 18 - (WL + 1)) @(posedge clk);
        #1 abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        for (int i = 0; i < WL + 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({busy, done, wr_en, err} !== 4'b0)
                $display("FAIL abort2_quiet c=%0d: got busy=%b done=%b wr_en=%b err=%b required 0/0/0/0", i, busy, done, wr_en, err);
            else n_pass++;
        end
        @(posedge clk); #1;
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, err, tp_rst} !== 3'b000)
            $display("FAIL abort_start_idle: got busy=%b err=%b tp_rst=%b required 0/0/0", busy, err, tp_rst);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        test_full_run("b2b_as", MODE_AS, 1, 32'h8000, 32'h9000, 32'hA000, 32'hB000, 32'h80, 32'h8, 32'h20);
        test_full_run("b2b_sa", MODE_SA, 3, 32'h400, 32'h800, 32'hC00, 32'hF00, 32'h20, 32'h4, 32'h10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2ms required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_as_basic();
        test_reject();
        test_sa_basic();
        test_wrap();
        test_abort();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sysarr_mem_seq.md
Name: sysarr_mem_seq

Overview:
Parametrised memory sequencer for the systolic-array matrix multiplier. It drives up to three read ports and one write port of the operand/result BRAMs, and steers operand data into the array. It supports two dataflows: AS (left×right streamed, result drained and accumulated) and SA (weights preloaded, left streamed, results accumulated and written back). Compared with the fixed 4-lane controller, it adds generic array dimension, runtime strides, a start/busy/done handshake, abort, error reporting and a programmable write-pipeline latency.

Parameters:
ARRAY_DIM, 4, systolic lanes per side D; power of two, ≥2; phase counter width PW = clog2(D).
DATA_W, 64, BRAM word / array lane-bus width.
ADDR_W, 32, byte-address width; all address arithmetic is modulo 2^ADDR_W.
ROWS_W, 11, width of matrix_rows.
WR_LAT, 2, cycles from read-address issue to the matching write (BRAM read latency + adder stage); ≥1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only in IDLE
mode  in  2  sysarr_pkg mode: 2'b01 AS, 2'b10 SA, others illegal
abort  in  1  synchronous abort; highest priority
matrix_rows  in  ROWS_W  N, number of streamed lines
base_left/base_right/base_add/base_save  in  ADDR_W each  region bases
line_stride  in  ADDR_W  address step per line
plane_left/plane_right  in  ADDR_W  address step per phase (left / right operand)
rd_data_0/1/2  in  DATA_W each  BRAM read data
rd_addr_0/1/2  out  ADDR_W each  BRAM read addresses
wr_en  out  1  result write strobe
wr_addr  out  ADDR_W  result write address
data_left/data_right/data_adder  out  DATA_W each  array operand buses / accumulate source
sa_compute  out  1  0 = load/shift, 1 = compute
sa_mode  out  1  1 = AS dataflow, 0 = SA
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on rejected start
state_o  out  3  current state encoding
tp_select  out  1  transposer bank select
tp_rst  out  1  transposer sync reset pulse

Behaviour:
- Reset values: all outputs 0, except tp_select = 1. State IDLE; counters and write pipe cleared.
- Start acceptance and rejection:
  - start in IDLE with N=0 or illegal mode: err=1 next cycle; stay IDLE; registers unchanged.
  - Valid start: latch all config; set sa_mode; clear ph/line; tp_rst=1 for exactly one cycle (next cycle); tp_select:=1.
  - start while busy is ignored.
- Counters:
  - ph cycles 0..D-1 every cycle while busy.
  - line increments when ph==D-1.
  - tp_select toggles in every cycle where busy and ph==0.
- States: IDLE, AS_CALC, AS_DRAIN, SA_LOAD, SA_CALC, FLUSH.
- AS_CALC (sa_compute=1):
  - rd_addr_0 = base_left + line*line_stride + ph*plane_left
  - rd_addr_1 = base_right + line*line_stride + ph*plane_right
  - data_left = rd_data_0; data_right = rd_data_1
  - Exit at line==N-1 & ph==D-1 → AS_DRAIN.
- AS_DRAIN:
  - Runs D line periods (D*D cycles); data buses 0.
  - First (D-1)*D cycles: sa_compute stays 1.
  - Last D cycles (k=ph): sa_compute=0; rd_addr_0 = base_add + k*line_stride; write issued to base_save + k*line_stride.
  - Then → FLUSH.
- SA_LOAD (sa_compute=0):
  - D cycles; rd_addr_0 = base_right + (D-1-ph)*plane_right; data_right = rd_data_0.
  - → SA_CALC with ph/line cleared.
- SA_CALC (sa_compute=1), line L = 0..N+D-1:
  - If L<N: rd_addr_2 = base_left + L*line_stride + ph*plane_left; data_left = rd_data_2. Otherwise data_left = 0.
  - If L≥D: o = L-D; rd_addr_0 = base_add + o*line_stride + ph*plane_left; write issued to base_save + o*line_stride + ph*plane_left.
  - data_adder = rd_data_0 in all states.
  - Exit at L==N+D-1 & ph==D-1 → FLUSH.
- Write pipe:
  - Each issued write (addr, valid) is delayed exactly WR_LAT cycles to wr_addr/wr_en.
  - wr_en is never asserted without a corresponding issue.
- FLUSH:
  - WR_LAT cycles; then done=1 for one cycle, busy=0, → IDLE.
  - done and busy never both 1; done coincides with return to IDLE.
- Abort:
  - Abort in any busy state → IDLE next cycle.
  - Write pipe cleared, so no wr_en from the next cycle onward. No done; busy falls.
  - abort and start in the same cycle: abort wins, start is ignored.
- Address arithmetic: implement with incremental accumulators (line base += line_stride; phase offset += plane), not multipliers. Results must equal the formulas mod 2^ADDR_W, wrap included.
- Unused read addresses are 0.

Decomposition:
- sysarr_pkg: state_t enum, mode codes MODE_AS/MODE_SA, state_o encoding.
- One sub-module: sysarr_wr_delay, a WR_LAT-deep shift register of {valid, addr} with synchronous clear (driven by abort) and async reset.

Test Plan:
- D=4, N=3, AS mode, bases 0x000/0x1000/0x2000/0x3000, line_stride 0x40, planes 0x100 → reset-to-first-issue gives rd_addr_0 = 0x0,0x100,0x200,0x300,0x40,... AS_CALC lasts 12 cycles; 4 writes to 0x3000,0x3040,0x3080,0x30C0 each WR_LAT after issue; done after 12+16+WR_LAT cycles.
- D=4, N=2, SA mode → SA_LOAD rd_addr_0 = base_right + 0x300,0x200,0x100,0x0; SA_CALC 24 cycles; exactly 8 writes, first at base_save+0x0, last at base_save+0x40+0x300.
- start with mode=2'b11, and separately with N=0 → err pulse one cycle, busy stays 0, no addresses change.
- abort at cycle 5 of SA_CALC with WR_LAT=3 → IDLE next cycle; zero wr_en afterwards; no done; an immediate new start is accepted.
- base_left=0xFFFF_FFC0, line_stride=0x40, N=2 (AS) → second line rd_addr_0 = 0x0000_0000 (wrap).
- Back-to-back: new start on the cycle after done → accepted; tp_rst pulses once; tp_select restarts at 1 and toggles on every ph==0.
